// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fix-up on the last edge.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic             hilo_we,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t r_state, w_next_state;

   logic [CW-1:0]    r_cnt;
   logic             r_is_div, r_neg_q, r_neg_r, r_bzero;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_low, r_opnd, r_hi, r_lo;

   logic             w_a_neg, w_b_neg, w_last;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;
   logic [WIDTH:0]   w_sum, w_msel, w_shift, w_diff, w_it_acc;
   logic [WIDTH-1:0] w_it_low, w_quot, w_rem;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;

   // Only the signed ops (op[0]==0) treat the top bit as a sign.
   assign w_a_neg = ~op[0] & busA[WIDTH-1];
   assign w_b_neg = ~op[0] & busB[WIDTH-1];
   assign w_a_mag = w_a_neg ? -busA : busA;
   assign w_b_mag = w_b_neg ? -busB : busB;
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   assign w_sum   = r_acc + {1'b0, r_opnd};
   assign w_msel  = r_low[0] ? w_sum : r_acc;
   assign w_shift = {r_acc[WIDTH-1:0], r_low[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_opnd};

   always_comb begin
      w_it_acc = r_acc;
      w_it_low = r_low;
      if (r_is_div) begin
         if (!w_diff[WIDTH]) begin
            w_it_acc = w_diff;
            w_it_low = {r_low[WIDTH-2:0], 1'b1};
         end else begin
            w_it_acc = w_shift;
            w_it_low = {r_low[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_it_acc = {1'b0, w_msel[WIDTH:1]};
         w_it_low = {w_msel[0], r_low[WIDTH-1:1]};
      end
   end

   assign w_prod     = {w_it_acc[WIDTH-1:0], w_it_low};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   // Divide by zero leaves the dividend magnitude in the remainder, so only the quotient is forced.
   assign w_quot     = r_bzero ? {WIDTH{1'b1}} : (r_neg_q ? -w_it_low : w_it_low);
   assign w_rem      = r_neg_r ? -w_it_acc[WIDTH-1:0] : w_it_acc[WIDTH-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_bzero  <= 1'b0;
         r_acc    <= '0;
         r_low    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_it_acc;
         r_low <= w_it_low;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_cnt <= '0;
            if (r_is_div) begin
               r_hi <= w_rem;
               r_lo <= w_quot;
            end else begin
               r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
               r_lo <= w_prod_fix[WIDTH-1:0];
            end
         end
      end else if (start) begin
         // Multiply keeps the multiplier in r_low; divide keeps the dividend there.
         r_cnt    <= '0;
         r_is_div <= op[1];
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_bzero  <= (busB == '0);
         r_acc    <= '0;
         r_low    <= op[1] ? w_a_mag : w_b_mag;
         r_opnd   <= op[1] ? w_b_mag : w_a_mag;
      end else if (hilo_we) begin
         if (hilo_sel) r_hi <= wdata;
         else          r_lo <= wdata;
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign hi   = r_hi;
   assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - table-driven and sequence checks for muldiv_unit
// Vectors carry hand-computed HI/LO; sequences cover ignored start/hilo_we, back-to-back, reset mid-run.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clock, reset, start, hilo_we, hilo_sel;
   logic [1:0]   op;
   logic [W-1:0] busA, busB, wdata, hi, lo;
   logic         busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, ehi, elo;
   } vec_t;
   vec_t vecs[12];

   muldiv_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .busA(busA), .busB(busB), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
      .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Called at the negedge right after the start edge was set up; returns at the DONE negedge.
   task automatic wait_result(input logic [W-1:0] ehi, input logic [W-1:0] elo,
                              input logic [W-1:0] phi, input logic [W-1:0] plo,
                              input string nm, input bit inject);
      int busy_n = 0;
      int hold_bad = 0;
      for (int i = 0; i < W; i++) begin
         @(negedge clock);
         if (busy && !done) busy_n++;
         if (hi !== phi || lo !== plo) hold_bad++;
         if (inject && i == 10) begin
            start = 1'b1; op = 2'b11; busA = $urandom; busB = 32'd1;
            hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hDEADBEEF;
         end else begin
            start = 1'b0; hilo_we = 1'b0; busA = $urandom; busB = $urandom;
         end
      end
      @(negedge clock);
      chk({nm, " busy_cycles"}, 64'(busy_n), 64'(W));
      chk({nm, " hold"}, 64'(hold_bad), 64'd0);
      chk({nm, " busy_done"}, {62'd0, busy, done}, 64'b01);
      chk({nm, " hi"}, 64'(hi), 64'(ehi));
      chk({nm, " lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      int bad;
      logic [W-1:0] phi, plo;

      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[8]  = '{2'b00, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};
      vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

      reset = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
      hilo_we = 1'b0; hilo_sel = 1'b0; wdata = '0;
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst hi", 64'(hi), 64'd0);
      chk("rst lo", 64'(lo), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      phi = '0; plo = '0;
      for (int i = 0; i < 12; i++) begin
         start = 1'b1; op = vecs[i].op; busA = vecs[i].a; busB = vecs[i].b;
         wait_result(vecs[i].ehi, vecs[i].elo, phi, plo, $sformatf("vec%0d", i), 1'b0);
         @(negedge clock);
         chk($sformatf("vec%0d idle", i), {62'd0, busy, done}, 64'b00);
         phi = vecs[i].ehi; plo = vecs[i].elo;
      end

      // Disturb mid-run, then hold start in DONE for a back-to-back DIVU.
      start = 1'b1; op = 2'b01; busA = 32'd3; busB = 32'd5;
      wait_result(32'd0, 32'd15, phi, plo, "inject", 1'b1);
      start = 1'b1; op = 2'b11; busA = 32'd100; busB = 32'd7;
      wait_result(32'd2, 32'd14, 32'd0, 32'd15, "b2b", 1'b0);

      hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h00005A5A;
      @(negedge clock);
      hilo_we = 1'b0;
      chk("mtlo_in_done lo", 64'(lo), 64'h5A5A);
      chk("mtlo_in_done hi", 64'(hi), 64'd2);
      hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h00000077;
      @(negedge clock);
      hilo_we = 1'b0;
      chk("mthi hi", 64'(hi), 64'h77);

      // hilo_we coinciding with start must be dropped; the hold check sees it.
      start = 1'b1; op = 2'b01; busA = 32'd2; busB = 32'd3;
      hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h00000BAD;
      wait_result(32'd0, 32'd6, 32'h77, 32'h5A5A, "we_with_start", 1'b0);

      @(negedge clock);
      start = 1'b1; op = 2'b11; busA = 32'h0000FFFF; busB = 32'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         start = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst done", 64'(done), 64'd0);
      chk("midrst hi", 64'(hi), 64'd0);
      chk("midrst lo", 64'(lo), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clock);
         if (done || busy) bad++;
      end
      chk("midrst no_done", 64'(bad), 64'd0);
      hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h0000A5A5;
      @(negedge clock);
      hilo_we = 1'b0;
      chk("mtlo lo", 64'(lo), 64'hA5A5);
      chk("mtlo hi", 64'(hi), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
